// File: rtl/control_vga.sv
// control_vga: sequencing FSM for the Connect-Four VGA drawer; each go change sweeps one 4x4 block.
// Optional macro CONTROL_VGA_PENDING_EN: a go change seen mid-sweep is queued and replayed right after done.
module control_vga #(
    parameter int PIX_MAX     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    output logic [3:0] pixel_count,
    output logic       done,
    output logic       plot
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW_PTR,
        DRAW_PLY,
        DONE
    } state_t;

    localparam logic [3:0] PIX_LAST = 4'(PIX_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   go_s;
    logic                   go_d;
    logic                   go_edge;

    state_t     state;
    state_t     state_next;
    logic [3:0] count_next;
    logic       plot_next;
    logic       done_next;

`ifdef CONTROL_VGA_PENDING_EN
    logic pending;
    logic pending_next;
`endif

    // go comes from a switch, so it is resynchronised before any edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            go_d   <= 1'b0;
        end else begin
            sync_q[0] <= go;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            go_d <= go_s;
        end
    end

    assign go_s    = sync_q[SYNC_STAGES-1];
    assign go_edge = go_s ^ go_d;

    always_comb begin
        state_next = state;
        count_next = '0;
        plot_next  = 1'b0;
        done_next  = 1'b0;
`ifdef CONTROL_VGA_PENDING_EN
        pending_next = pending;
`endif
        case (state)
            IDLE: begin
                if (go_edge) begin
                    state_next = go_s ? DRAW_PLY : DRAW_PTR;
                    plot_next  = 1'b1;
                end
            end
            DRAW_PTR, DRAW_PLY: begin
`ifdef CONTROL_VGA_PENDING_EN
                if (go_edge) begin
                    pending_next = 1'b1;
                end
`endif
                if (pixel_count >= PIX_LAST) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    count_next = pixel_count + 4'd1;
                    plot_next  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
`ifdef CONTROL_VGA_PENDING_EN
                // an edge landing in the done cycle itself is folded into the pending request
                if (pending || go_edge) begin
                    state_next   = go_s ? DRAW_PLY : DRAW_PTR;
                    plot_next    = 1'b1;
                    pending_next = 1'b0;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pixel_count <= '0;
            plot        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            pixel_count <= count_next;
            plot        <= plot_next;
            done        <= done_next;
        end
    end

`ifdef CONTROL_VGA_PENDING_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_next;
        end
    end
`endif

endmodule

// File: tb/tb_control_vga.sv
// tb_control_vga: directed and random go/reset stimulus against a sweep-position reference model.
// Honours CONTROL_VGA_PENDING_EN the same way the design does.
module tb_control_vga;

    localparam int PIX_MAX     = 15;
    localparam int SYNC_STAGES = 2;

`ifdef CONTROL_VGA_PENDING_EN
    localparam bit PENDING = 1'b1;
`else
    localparam bit PENDING = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       go     = 1'b0;
    logic [3:0] pixel_count;
    logic       done;
    logic       plot;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: pos is -1 when idle, 0..PIX_MAX while plotting, PIX_MAX+1 in the done cycle
    int pos;
    bit pend;
    bit gd;
    bit gpipe [SYNC_STAGES];

    int plot_tally;
    int done_tally;

    control_vga #(
        .PIX_MAX    (PIX_MAX),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .pixel_count(pixel_count),
        .done       (done),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        pos  = -1;
        pend = 1'b0;
        gd   = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) gpipe[i] = 1'b0;
    endtask

    task automatic modelEdge();
        bit gs;
        bit e;
        gs = gpipe[SYNC_STAGES-1];
        e  = gs ^ gd;
        if (pos < 0) begin
            if (e) pos = 0;
        end else if (pos <= PIX_MAX) begin
            pos++;
            if (e) pend = 1'b1;
        end else begin
            if (PENDING && (pend || e)) pos = 0;
            else pos = -1;
            pend = 1'b0;
        end
        gd = gs;
        for (int i = SYNC_STAGES - 1; i > 0; i--) gpipe[i] = gpipe[i-1];
        gpipe[0] = go;
    endtask

    task automatic compareAll(input string tag);
        bit exp_plot;
        exp_plot = (pos >= 0) && (pos <= PIX_MAX);
        checkOutput({tag, ".plot"}, 32'(plot), 32'(exp_plot));
        checkOutput({tag, ".done"}, 32'(done), 32'(pos == PIX_MAX + 1));
        checkOutput({tag, ".pixel_count"}, 32'(pixel_count), exp_plot ? 32'(pos) : 32'd0);
    endtask

    task automatic stepCycle(input string tag);
        @(posedge clk);
        if (resetn) modelEdge();
        #1;
        compareAll(tag);
        if (plot === 1'b1) plot_tally++;
        if (done === 1'b1) done_tally++;
    endtask

    task automatic applyStimulus(input logic go_val, input int cycles, input string tag);
        go = go_val;
        for (int i = 0; i < cycles; i++) stepCycle(tag);
    endtask

    task automatic assertReset(input string tag);
        resetn = 1'b0;
        modelReset();
        #1;
        compareAll({tag, ".async"});
    endtask

    task automatic waitPixel(input int target, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            stepCycle(tag);
            if (plot === 1'b1 && pixel_count == 4'(target)) found = 1'b1;
        end
        checkOutput({tag, ".reached"}, 32'(found), 32'd1);
    endtask

    task automatic clearTally();
        plot_tally = 0;
        done_tally = 0;
    endtask

    initial begin
        modelReset();
        clearTally();
        resetn = 1'b0;
        go     = 1'b0;
        #1;
        compareAll("reset");
        repeat (3) stepCycle("reset");
        resetn = 1'b1;

        clearTally();
        applyStimulus(1'b0, 50, "idle");
        checkOutput("idle.plots", 32'(plot_tally), 32'd0);

        clearTally();
        applyStimulus(1'b1, 25, "player");
        checkOutput("player.plots", 32'(plot_tally), 32'(PIX_MAX + 1));
        checkOutput("player.dones", 32'(done_tally), 32'd1);

        clearTally();
        applyStimulus(1'b1, 8, "gap");
        applyStimulus(1'b0, 25, "pointer");
        checkOutput("pointer.plots", 32'(plot_tally), 32'(PIX_MAX + 1));
        checkOutput("pointer.dones", 32'(done_tally), 32'd1);

        clearTally();
        go = 1'b1;
        waitPixel(5, "busy");
        applyStimulus(1'b0, 45, "busy");
        checkOutput("busy.plots", 32'(plot_tally), PENDING ? 32'(2 * (PIX_MAX + 1)) : 32'(PIX_MAX + 1));
        checkOutput("busy.dones", 32'(done_tally), PENDING ? 32'd2 : 32'd1);

        applyStimulus(1'b1, 25, "pre_abort");
        clearTally();
        go = 1'b0;
        waitPixel(7, "abort");
        assertReset("abort");
        clearTally();
        repeat (3) stepCycle("abort_hold");
        resetn = 1'b1;
        applyStimulus(1'b0, 30, "abort_after");
        checkOutput("abort.plots", 32'(plot_tally), 32'd0);
        checkOutput("abort.dones", 32'(done_tally), 32'd0);

        assertReset("powerup");
        go = 1'b1;
        repeat (3) stepCycle("powerup_hold");
        resetn = 1'b1;
        clearTally();
        applyStimulus(1'b1, 40, "powerup");
        checkOutput("powerup.plots", 32'(plot_tally), 32'(PIX_MAX + 1));
        checkOutput("powerup.dones", 32'(done_tally), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                assertReset("rand_rst");
                repeat ($urandom_range(1, 3)) stepCycle("rand_rst");
                resetn = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) go = ~go;
            stepCycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
